// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the VGA scan generator and compositor.
// Coordinates are signed so blanking is negative and active video starts at 0.
package vga_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_RES_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    typedef logic [11:0]        colr_t;
    typedef logic signed [15:0] coord_t;

    // Raw scan qualifiers; hs/vs are active low, de high in active video.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Scan counter: signed sx/sy, registered line/frame strobes and raw sync/de
// decoded combinationally from the current counter values.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    output coord_t sx,
    output coord_t sy,
    output logic   line,
    output logic   frame,
    output sync_t  sync_raw
);

    localparam coord_t H_STA  = coord_t'(-(H_FP + H_SYNC + H_BP));
    localparam coord_t HS_STA = coord_t'(-(H_SYNC + H_BP));
    localparam coord_t HS_END = coord_t'(-H_BP - 1);
    localparam coord_t HA_END = coord_t'(H_RES - 1);
    localparam coord_t V_STA  = coord_t'(-(V_FP + V_SYNC + V_BP));
    localparam coord_t VS_STA = coord_t'(-(V_SYNC + V_BP));
    localparam coord_t VS_END = coord_t'(-V_BP - 1);
    localparam coord_t VA_END = coord_t'(V_RES - 1);

    coord_t sx_q, sx_d;
    coord_t sy_q, sy_d;
    logic   line_q, line_d;
    logic   frame_q, frame_d;

    always_comb begin
        sx_d = sx_q + 16'sd1;
        sy_d = sy_q;
        if (sx_q == HA_END) begin
            sx_d = H_STA;
            if (sy_q == VA_END) begin
                sy_d = V_STA;
            end else begin
                sy_d = sy_q + 16'sd1;
            end
        end
        // Strobes are computed from the next count so they land with it.
        line_d  = (sx_d == H_STA);
        frame_d = line_d && (sy_d == V_STA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q    <= H_STA;
            sy_q    <= V_STA;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        sync_raw    = SYNC_IDLE;
        sync_raw.hs = !((sx_q >= HS_STA) && (sx_q <= HS_END));
        sync_raw.vs = !((sy_q >= VS_STA) && (sy_q <= VS_END));
        sync_raw.de = (sx_q >= 16'sd0) && (sy_q >= 16'sd0);
    end

    assign sx    = sx_q;
    assign sy    = sy_q;
    assign line  = line_q;
    assign frame = frame_q;

endmodule

// File: rtl/vga_frame_compositor.sv
// Scan timing plus layer compositing: raw sync/de are delayed to meet the
// layers' pipeline, the highest-priority drawing layer wins, outputs registered.
module vga_frame_compositor
    import vga_pkg::*;
#(
    parameter int    H_RES      = H_RES_DEF,
    parameter int    H_FP       = H_FP_DEF,
    parameter int    H_SYNC     = H_SYNC_DEF,
    parameter int    H_BP       = H_BP_DEF,
    parameter int    V_RES      = V_RES_DEF,
    parameter int    V_FP       = V_FP_DEF,
    parameter int    V_SYNC     = V_SYNC_DEF,
    parameter int    V_BP       = V_BP_DEF,
    parameter int    NUM_LAYERS = 4,
    parameter int    LAYER_LAT  = 2,
    parameter colr_t BG_COLR    = 12'h000,
    parameter bit    TRANS_EN   = 1'b0,
    parameter colr_t TRANS_KEY  = 12'hF0F
) (
    input  logic                       i_clk_25,
    input  logic                       i_rst_n,
    output coord_t                     sx,
    output coord_t                     sy,
    output logic                       line,
    output logic                       frame,
    input  logic [12*NUM_LAYERS-1:0]   layer_colr,
    input  logic [NUM_LAYERS-1:0]      layer_drawing,
    output logic [3:0]                 o_vga_r,
    output logic [3:0]                 o_vga_g,
    output logic [3:0]                 o_vga_b,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic                       o_blank_n
);

    sync_t sync_raw;
    sync_t sync_al;

    vga_timing #(
        .H_RES  (H_RES),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_RES  (V_RES),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk      (i_clk_25),
        .rst_n    (i_rst_n),
        .sx       (sx),
        .sy       (sy),
        .line     (line),
        .frame    (frame),
        .sync_raw (sync_raw)
    );

    generate
        if (LAYER_LAT == 0) begin : g_no_dly
            assign sync_al = sync_raw;
        end else begin : g_dly
            sync_t dly_q [LAYER_LAT];
            sync_t dly_d [LAYER_LAT];

            always_comb begin
                dly_d[0] = sync_raw;
                for (int i = 1; i < LAYER_LAT; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < LAYER_LAT; i++) begin
                        dly_q[i] <= SYNC_IDLE;
                    end
                end else begin
                    for (int i = 0; i < LAYER_LAT; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign sync_al = dly_q[LAYER_LAT-1];
        end
    endgenerate

    colr_t pix_colr;
    colr_t lay_c;
    logic  found;

    // Lowest index wins; a keyed colour counts as not drawing when enabled.
    always_comb begin
        pix_colr = BG_COLR;
        found    = 1'b0;
        lay_c    = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            lay_c = layer_colr[12*k +: 12];
            if (!found && layer_drawing[k] && !(TRANS_EN && (lay_c == TRANS_KEY))) begin
                pix_colr = lay_c;
                found    = 1'b1;
            end
        end
    end

    colr_t rgb_q, rgb_d;
    logic  hsync_q, hsync_d;
    logic  vsync_q, vsync_d;
    logic  blank_n_q, blank_n_d;

    always_comb begin
        rgb_d     = sync_al.de ? pix_colr : 12'h000;
        hsync_d   = sync_al.hs;
        vsync_d   = sync_al.vs;
        blank_n_d = sync_al.de;
    end

    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_q     <= 12'h000;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign o_vga_r   = rgb_q[11:8];
    assign o_vga_g   = rgb_q[7:4];
    assign o_vga_b   = rgb_q[3:0];
    assign o_hsync   = hsync_q;
    assign o_vsync   = vsync_q;
    assign o_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_frame_compositor.sv
// Bench for vga_frame_compositor: a reduced-timing instance (plain and keyed)
// plus a default-timing instance, all compared against an arithmetic scan model.
module tb_vga_frame_compositor;

    // Reduced timing: 80 x 55 = 4400-cycle frame keeps full frames cheap.
    localparam int S_HRES = 64, S_HFP = 4, S_HSY = 8, S_HBP = 4;
    localparam int S_VRES = 48, S_VFP = 2, S_VSY = 2, S_VBP = 3;
    localparam int S_HT = S_HRES + S_HFP + S_HSY + S_HBP;
    localparam int S_VT = S_VRES + S_VFP + S_VSY + S_VBP;
    localparam int S_HB = S_HFP + S_HSY + S_HBP;
    localparam int S_VB = S_VFP + S_VSY + S_VBP;

    logic        clk;
    logic        rst_n;
    logic [47:0] layer_colr;
    logic [3:0]  layer_drawing;

    logic signed [15:0] s_sx, s_sy, t_sx, t_sy, d_sx, d_sy;
    logic s_line, s_frame, s_hs, s_vs, s_bn;
    logic t_line, t_frame, t_hs, t_vs, t_bn;
    logic d_line, d_frame, d_hs, d_vs, d_bn;
    logic [3:0] s_r, s_g, s_b, t_r, t_g, t_b, d_r, d_g, d_b;

    int n_tests = 0;
    int n_fail  = 0;
    int e       = 0;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    vga_frame_compositor #(
        .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
        .TRANS_EN(1'b0)
    ) dut_s (
        .i_clk_25(clk), .i_rst_n(rst_n), .sx(s_sx), .sy(s_sy),
        .line(s_line), .frame(s_frame), .layer_colr(layer_colr),
        .layer_drawing(layer_drawing), .o_vga_r(s_r), .o_vga_g(s_g),
        .o_vga_b(s_b), .o_hsync(s_hs), .o_vsync(s_vs), .o_blank_n(s_bn)
    );

    vga_frame_compositor #(
        .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
        .TRANS_EN(1'b1)
    ) dut_t (
        .i_clk_25(clk), .i_rst_n(rst_n), .sx(t_sx), .sy(t_sy),
        .line(t_line), .frame(t_frame), .layer_colr(layer_colr),
        .layer_drawing(layer_drawing), .o_vga_r(t_r), .o_vga_g(t_g),
        .o_vga_b(t_b), .o_hsync(t_hs), .o_vsync(t_vs), .o_blank_n(t_bn)
    );

    vga_frame_compositor dut_d (
        .i_clk_25(clk), .i_rst_n(rst_n), .sx(d_sx), .sy(d_sy),
        .line(d_line), .frame(d_frame), .layer_colr(layer_colr),
        .layer_drawing(layer_drawing), .o_vga_r(d_r), .o_vga_g(d_g),
        .o_vga_b(d_b), .o_hsync(d_hs), .o_vsync(d_vs), .o_blank_n(d_bn)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, e);
        end
    endtask

    // Position of the scan after n clocks from reset release.
    function automatic void coord(input int n, input int ht, input int vt,
                                  input int hb, input int vb,
                                  output int x, output int y);
        int pos;
        pos = n % (ht * vt);
        x = (pos % ht) - hb;
        y = (pos / ht) - vb;
    endfunction

    function automatic int resolve(input logic [47:0] c, input logic [3:0] d, input bit ten);
        for (int k = 0; k < 4; k++) begin
            if (d[k] && !(ten && c[12*k +: 12] == 12'hF0F)) return int'(c[12*k +: 12]);
        end
        return 0;
    endfunction

    task automatic chk_out(input string p,
                           input int hres, input int hfp, input int hsy, input int hbp,
                           input int vres, input int vfp, input int vsy, input int vbp,
                           input bit ten,
                           input int g_sx, input int g_sy, input int g_line, input int g_frame,
                           input int g_hs, input int g_vs, input int g_bn, input int g_rgb);
        int ht, vt, hb, vb, x, y, ax, ay;
        int x_line, x_frame, x_hs, x_vs, x_de, x_rgb;
        ht = hres + hfp + hsy + hbp;
        vt = vres + vfp + vsy + vbp;
        hb = hfp + hsy + hbp;
        vb = vfp + vsy + vbp;
        coord(e, ht, vt, hb, vb, x, y);
        x_line  = (e > 0 && x == -hb) ? 1 : 0;
        x_frame = (x_line == 1 && y == -vb) ? 1 : 0;
        x_hs = 1; x_vs = 1; x_de = 0; x_rgb = 0;
        if (e >= 3) begin
            coord(e - 3, ht, vt, hb, vb, ax, ay);
            x_hs = (ax >= -(hsy + hbp) && ax < -hbp) ? 0 : 1;
            x_vs = (ay >= -(vsy + vbp) && ay < -vbp) ? 0 : 1;
            x_de = (ax >= 0 && ay >= 0) ? 1 : 0;
            x_rgb = x_de ? resolve(layer_colr, layer_drawing, ten) : 0;
        end
        check({p, "_sx"}, g_sx, x);
        check({p, "_sy"}, g_sy, y);
        check({p, "_line"}, g_line, x_line);
        check({p, "_frame"}, g_frame, x_frame);
        check({p, "_hsync"}, g_hs, x_hs);
        check({p, "_vsync"}, g_vs, x_vs);
        check({p, "_blank_n"}, g_bn, x_de);
        check({p, "_rgb"}, g_rgb, x_rgb);
    endtask

    task automatic chk_reset(input string p, input int g_sx, input int g_sy,
                             input int g_line, input int g_frame, input int g_hs,
                             input int g_vs, input int g_bn, input int g_rgb,
                             input int hb, input int vb);
        check({p, "_rst_sx"}, g_sx, -hb);
        check({p, "_rst_sy"}, g_sy, -vb);
        check({p, "_rst_line"}, g_line, 0);
        check({p, "_rst_frame"}, g_frame, 0);
        check({p, "_rst_hsync"}, g_hs, 1);
        check({p, "_rst_vsync"}, g_vs, 1);
        check({p, "_rst_blank_n"}, g_bn, 0);
        check({p, "_rst_rgb"}, g_rgb, 0);
    endtask

    task automatic chk_reset_all();
        chk_reset("s", s_sx, s_sy, s_line, s_frame, s_hs, s_vs, s_bn, {s_r, s_g, s_b}, S_HB, S_VB);
        chk_reset("t", t_sx, t_sy, t_line, t_frame, t_hs, t_vs, t_bn, {t_r, t_g, t_b}, S_HB, S_VB);
        chk_reset("d", d_sx, d_sy, d_line, d_frame, d_hs, d_vs, d_bn, {d_r, d_g, d_b}, 160, 45);
    endtask

    function automatic logic [11:0] rand_colr();
        case ($urandom_range(0, 4))
            0: return 12'hF0F;
            1: return 12'hF00;
            2: return 12'h0F0;
            3: return 12'h00F;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic drive_random();
        for (int k = 0; k < 4; k++) layer_colr[12*k +: 12] = rand_colr();
        layer_drawing = 4'($urandom_range(0, 15));
    endtask

    // Layer data driven now is composited for the scan position two clocks back.
    task automatic drive_layers();
        int x, y;
        drive_random();
        if (e < 2) return;
        coord(e - 2, S_HT, S_VT, S_HB, S_VB, x, y);
        if (y == 5) begin
            case (x)
                10: begin layer_colr = {12'h000, 12'h0F0, 12'h00F, 12'hF00}; layer_drawing = 4'b0101; end
                11: begin layer_colr = {12'h000, 12'h0F0, 12'h00F, 12'hF00}; layer_drawing = 4'b0100; end
                12: layer_drawing = 4'b0000;
                13: begin layer_colr = {12'h000, 12'h000, 12'h00F, 12'hF0F}; layer_drawing = 4'b0011; end
                -5: begin layer_colr = {4{12'hFFF}}; layer_drawing = 4'b1111; end
                default: ;
            endcase
        end
    endtask

    int hs_run, vs_run, line_cnt, last_frame_e, hs_mark;
    bit seen_frame, prev_hs;

    task automatic clear_track();
        hs_run = 0; vs_run = 0; line_cnt = 0; last_frame_e = 0;
        hs_mark = -1000; seen_frame = 0; prev_hs = 1;
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        #1;
        chk_out("s", S_HRES, S_HFP, S_HSY, S_HBP, S_VRES, S_VFP, S_VSY, S_VBP, 1'b0,
                s_sx, s_sy, s_line, s_frame, s_hs, s_vs, s_bn, {s_r, s_g, s_b});
        chk_out("t", S_HRES, S_HFP, S_HSY, S_HBP, S_VRES, S_VFP, S_VSY, S_VBP, 1'b1,
                t_sx, t_sy, t_line, t_frame, t_hs, t_vs, t_bn, {t_r, t_g, t_b});
        chk_out("d", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                d_sx, d_sy, d_line, d_frame, d_hs, d_vs, d_bn, {d_r, d_g, d_b});
        if (s_frame) begin
            if (seen_frame) begin
                check("frame_period", e - last_frame_e, S_HT * S_VT);
                check("lines_per_frame", line_cnt, S_VT);
            end
            seen_frame = 1;
            last_frame_e = e;
            line_cnt = 0;
        end
        if (s_line) line_cnt++;
        if (s_sx == -(S_HSY + S_HBP)) hs_mark = e;
        if (prev_hs && !s_hs) check("hsync_start_lag", e - hs_mark, 3);
        prev_hs = s_hs;
        if (!s_hs) hs_run++;
        else if (hs_run > 0) begin check("hsync_width", hs_run, S_HSY); hs_run = 0; end
        if (!s_vs) vs_run++;
        else if (vs_run > 0) begin check("vsync_width", vs_run, S_VSY * S_HT); vs_run = 0; end
        drive_layers();
    endtask

    initial begin
        bit hit;
        int x, y;
        rst_n = 1'b0;
        drive_random();
        clear_track();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_random();
            #1;
            chk_reset_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        for (int i = 0; i < 9000; i++) step();
        check("two_frames_seen", int'(seen_frame), 1);

        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            step();
            coord(e, S_HT, S_VT, S_HB, S_VB, x, y);
            hit = (x == 30 && y == 20);
        end
        check("midframe_point_found", int'(hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_all();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_random();
            #1;
            chk_reset_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        clear_track();
        for (int i = 0; i < 900; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_compositor.md
Name: vga_frame_compositor

Overview:
- Display-side counterpart of the sprite item blocks.
- Generates the 640x480@60 scan timing: signed sx/sy, line and frame strobes. Every sprite layer consumes these.
- Collects each layer's colour and drawing flag after the layers' fixed pipeline latency, and resolves layer priority.
- Drives the registered VGA RGB, sync and blank outputs, aligned to the pixel the layers were asked to draw.

Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_RES, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- NUM_LAYERS, 4, sprite layer inputs; layer 0 has the highest priority
- LAYER_LAT, 2, cycles from sx/sy valid to layer colr/drawing valid
- BG_COLR, 12'h000, colour shown where no layer draws
- TRANS_EN, 0, when 1 a layer whose colour equals TRANS_KEY is treated as not drawing
- TRANS_KEY, 12'hF0F, transparent colour key

Ports:
- i_clk_25, input, 1, 25 MHz pixel clock
- i_rst_n, input, 1, reset
- sx, output, 16 signed, horizontal coordinate
- sy, output, 16 signed, vertical coordinate
- line, output, 1, one-cycle strobe at the start of every line
- frame, output, 1, one-cycle strobe at the start of every frame
- layer_colr, input, 12*NUM_LAYERS, layer k colour in bits [12k+11:12k]
- layer_drawing, input, NUM_LAYERS, layer k drawing flag
- o_vga_r, output, 4, red
- o_vga_g, output, 4, green
- o_vga_b, output, 4, blue
- o_hsync, output, 1, active-low hsync
- o_vsync, output, 1, active-low vsync
- o_blank_n, output, 1, high during active video

Interface decision: one clock; reset is asynchronous and active-low; clock port i_clk_25, reset port i_rst_n.

Behaviour:
- Coordinate ranges:
  - sx runs -(H_FP+H_SYNC+H_BP) .. H_RES-1, which is -160..639 at defaults.
  - sy runs -(V_FP+V_SYNC+V_BP) .. V_RES-1, which is -45..479 at defaults.
  - Blanking is negative; active video is sx>=0 && sy>=0.
- Counting:
  - sx increments every cycle.
  - At 639, sx wraps to -160 and sy increments.
  - At sy=479 with sx=639, both wrap to their minimum.
  - Frame = 800x525 = 420000 cycles.
- line and frame are registered and coincide with the cycle their counters hold the condition.
  - line=1 when sx==-160.
  - frame=1 when sx==-160 && sy==-45.
- Sync timing at defaults, both syncs active low:
  - hsync raw = 0 for sx in -144..-49.
  - vsync raw = 0 for sy in -35..-34 (whole lines).
  - de raw = active video.
- Alignment:
  - hsync/vsync/de raw pass through a LAYER_LAT-deep delay line, so they align with layer data.
  - The output stage registers once more.
  - Total latency from sx/sy to o_* is LAYER_LAT+1 cycles (3 at defaults).
- Priority resolve (combinational, at the aligned stage):
  - Pick the lowest k with layer_drawing[k]=1, and not (TRANS_EN && colr_k==TRANS_KEY).
  - Output colr_k; if no layer qualifies, output BG_COLR.
- Blanking: when aligned de=0, RGB is forced to 0 regardless of layer inputs.
- Reset (asynchronous, any time including mid-frame):
  - sx=-160, sy=-45, line=0, frame=0.
  - Delay lines cleared to the inactive state (sync=1, de=0).
  - o_hsync=1, o_vsync=1, o_blank_n=0, RGB=0.
- After reset release:
  - First clock moves sx to -159.
  - First line strobe occurs 799 cycles later, with sy=-44.
  - First frame strobe occurs 420000 cycles after release.
- Widths: counters are 16-bit signed; comparisons are signed; no overflow is possible with the parameter limits (totals < 32768).

Decomposition:
- Package vga_pkg holds:
  - localparams for the default timing values;
  - typedef colr_t (logic [11:0]);
  - typedef coord_t (logic signed [15:0]).
- One sub-module, vga_timing, holds counters, line/frame and raw sync/de generation. It is reusable standalone.
- The compositor proper (delay line, priority mux, output registers) stays in vga_frame_compositor.

Test Plan:
- Reset state: hold i_rst_n=0 with random layer inputs -> sx=-160, sy=-45, line=0, frame=0, o_hsync=1, o_vsync=1, o_blank_n=0, RGB=0.
- Frame timing over two frames:
  - exactly 525 line pulses between frame pulses;
  - frame period 420000 cycles;
  - o_hsync low for 96 cycles, starting 3 cycles after sx=-144;
  - o_vsync low for 1600 cycles.
- Priority: at sx=100, sy=50, drive layer 0 (F00, drawing) and layer 2 (0F0, drawing) -> RGB=F,0,0 three cycles later. With layer 0 not drawing -> 0,F,0. With none drawing -> BG_COLR (0,0,0).
- Transparency: TRANS_EN=1, layer 0 colr=F0F drawing, layer 1 colr=00F drawing -> RGB=0,0,F.
- Blanking: all layers drawing colour FFF while sx=-10 -> RGB=0 and o_blank_n=0 at the aligned cycle.
- Mid-frame reset: assert i_rst_n=0 at sx=300, sy=200 -> outputs immediately return to reset values; after release, the first line pulse comes 799 cycles later with sy=-44.
